// File: rtl/fir_tap_window.sv
// Sliding 4-sample delay line feeding a 4-tap FIR parallel input, with priming and decimation.
// Latency: window registered on m_window/m_valid one cycle after the accepting edge.
// Backpressure: s_ready drops while an unconsumed window is held; consume and accept can share an edge.
module fir_tap_window #(
  parameter int DW     = 16,
  parameter int STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4*DW-1:0] m_window,
  output logic            primed
);

  typedef enum logic {FILL, RUN} state_t;

  localparam logic [3:0] STRIDE_L = 4'(STRIDE);

  state_t          state_q, state_d;
  logic [4*DW-1:0] line_q, line_d;
  logic [4*DW-1:0] win_d;
  logic            vld_d;
  logic            primed_d;
  logic [2:0]      fill_q, fill_d;
  logic [3:0]      stride_q, stride_d, stride_inc;
  logic            accept;
  logic            emit;

  // Ready never looks at s_valid; a held window stalls every accept, emitting or not.
  assign s_ready    = !flush && (!m_valid || m_ready);
  assign accept     = s_valid && s_ready;
  assign stride_inc = stride_q + 4'd1;

  // Next-state: flush wins, otherwise consume, shift on accept and decide whether a window emits.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    win_d    = m_window;
    vld_d    = m_valid;
    primed_d = primed;
    fill_d   = fill_q;
    stride_d = stride_q;
    emit     = 1'b0;
    if (flush) begin
      state_d  = FILL;
      line_d   = '0;
      win_d    = '0;
      vld_d    = 1'b0;
      primed_d = 1'b0;
      fill_d   = 3'd0;
      stride_d = 4'd0;
    end else begin
      if (m_valid && m_ready) begin
        vld_d = 1'b0;
      end
      if (accept) begin
        // Newest sample lands in the low lane, oldest falls off the top.
        line_d = {line_q[3*DW-1:0], s_data};
        case (state_q)
          FILL: begin
            if (fill_q != 3'd4) begin
              fill_d = fill_q + 3'd1;
            end
            if (fill_q == 3'd3) begin
              emit     = 1'b1;
              state_d  = RUN;
              primed_d = 1'b1;
              stride_d = 4'd0;
            end
          end
          RUN: begin
            if (stride_inc == STRIDE_L) begin
              emit     = 1'b1;
              stride_d = 4'd0;
            end else begin
              stride_d = stride_inc;
            end
          end
        endcase
        if (emit) begin
          win_d = line_d;
          vld_d = 1'b1;
        end
      end
    end
  end

  // State register; async reset clears everything including a pending window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      line_q   <= '0;
      m_window <= '0;
      m_valid  <= 1'b0;
      primed   <= 1'b0;
      fill_q   <= 3'd0;
      stride_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      m_window <= win_d;
      m_valid  <= vld_d;
      primed   <= primed_d;
      fill_q   <= fill_d;
      stride_q <= stride_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_window.sv
// Bench for fir_tap_window: STRIDE=1 instance for priming/streaming/backpressure/flush/reset,
// STRIDE=3 instance for decimation. Expected windows are queued when stimulus is driven
// and popped by per-instance monitors at each output handshake.
module tb_fir_tap_window;

  logic        clk;
  logic        rst_n;

  logic        flush, s_valid, s_ready, m_valid, m_ready, primed;
  logic [15:0] s_data;
  logic [63:0] m_window;

  logic        flush3, s_valid3, s_ready3, m_valid3, m_ready3, primed3;
  logic [15:0] s_data3;
  logic [63:0] m_window3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q1[$];
  logic [63:0] q3[$];

  fir_tap_window #(.DW(16), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window),
    .primed(primed)
  );

  fir_tap_window #(.DW(16), .STRIDE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .m_valid(m_valid3), .m_ready(m_ready3), .m_window(m_window3),
    .primed(primed3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so a negedge handshake sample is the one the next edge commits.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL sb1_unexpected: got window %h, expected none", m_window);
      end else begin
        logic [63:0] e;
        e = q1.pop_front();
        if (m_window !== e) begin
          n_bad++;
          $display("FAIL sb1_window: got %h expected %h", m_window, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid3 && m_ready3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL sb3_unexpected: got window %h, expected none", m_window3);
      end else begin
        logic [63:0] e;
        e = q3.pop_front();
        if (m_window3 !== e) begin
          n_bad++;
          $display("FAIL sb3_window: got %h expected %h", m_window3, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; s_valid = 0; s_data = 0; m_ready = 1;
    flush3 = 0; s_valid3 = 0; s_data3 = 0; m_ready3 = 1;
    #12;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_primed", 64'(primed), 64'd0);
    chk("reset_m_window", m_window, 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_priming();
    m_ready = 1; s_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 16'(k);
      if (k == 4) q1.push_back(64'h0001_0002_0003_0004);
      tick();
      if (k < 4) begin
        chk($sformatf("prime_no_valid_%0d", k), 64'(m_valid), 64'd0);
        chk($sformatf("prime_not_primed_%0d", k), 64'(primed), 64'd0);
      end else begin
        chk("prime_valid", 64'(m_valid), 64'd1);
        chk("prime_primed", 64'(primed), 64'd1);
        chk("prime_window", m_window, 64'h0001_0002_0003_0004);
      end
    end
  endtask

  task automatic test_streaming();
    s_data = 16'h0005;
    q1.push_back(64'h0002_0003_0004_0005);
    tick();
    chk("stream_no_bubble", 64'(m_valid), 64'd1);
    chk("stream_window", m_window, 64'h0002_0003_0004_0005);
    s_valid = 0;
    tick();
    chk("stream_drain", 64'(m_valid), 64'd0);
    chk("stream_queue_empty", 64'(q1.size()), 64'd0);
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    held = 64'h0003_0004_0005_0006;
    m_ready = 0; s_valid = 1; s_data = 16'h0006;
    q1.push_back(held);
    tick();
    chk("bp_valid", 64'(m_valid), 64'd1);
    s_data = 16'h0007;
    #1;
    chk("bp_s_ready_low", 64'(s_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_frozen_%0d", c), m_window, held);
      chk($sformatf("bp_s_ready_%0d", c), 64'(s_ready), 64'd0);
    end
    m_ready = 1;
    q1.push_back(64'h0004_0005_0006_0007);
    #1;
    chk("bp_release_s_ready", 64'(s_ready), 64'd1);
    tick();
    chk("bp_next_valid", 64'(m_valid), 64'd1);
    chk("bp_next_window", m_window, 64'h0004_0005_0006_0007);
    s_valid = 0;
    tick();
    chk("bp_drain", 64'(m_valid), 64'd0);
    chk("bp_queue_empty", 64'(q1.size()), 64'd0);
  endtask

  task automatic test_decimation();
    m_ready3 = 1; s_valid3 = 1;
    for (int k = 1; k <= 10; k++) begin
      s_data3 = 16'(k);
      if (k == 4)  q3.push_back(64'h0001_0002_0003_0004);
      if (k == 7)  q3.push_back(64'h0004_0005_0006_0007);
      if (k == 10) q3.push_back(64'h0007_0008_0009_000A);
      tick();
      chk($sformatf("dec_valid_after_%0d", k), 64'(m_valid3),
          (k == 4 || k == 7 || k == 10) ? 64'd1 : 64'd0);
    end
    s_valid3 = 0;
    tick();
    chk("dec_queue_empty", 64'(q3.size()), 64'd0);
  endtask

  task automatic test_flush();
    m_ready = 1; s_valid = 0; flush = 1;
    tick();
    flush = 0;
    chk("flush_clear_primed", 64'(primed), 64'd0);
    s_valid = 1;
    s_data = 16'h0011; tick();
    s_data = 16'h0012; tick();
    flush = 1; s_data = 16'h00EE;
    #1;
    chk("flush_s_ready", 64'(s_ready), 64'd0);
    tick();
    flush = 0;
    chk("flush_primed", 64'(primed), 64'd0);
    chk("flush_m_valid", 64'(m_valid), 64'd0);
    chk("flush_m_window", m_window, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      s_data = 16'(16'h0020 + k);
      if (k == 4) q1.push_back(64'h0021_0022_0023_0024);
      tick();
      chk($sformatf("flush_refill_valid_%0d", k), 64'(m_valid), (k == 4) ? 64'd1 : 64'd0);
    end
    s_valid = 0;
    tick();
    chk("flush_queue_empty", 64'(q1.size()), 64'd0);
  endtask

  task automatic test_async_reset();
    m_ready = 0; s_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 16'(16'h0030 + k);
      tick();
    end
    s_valid = 0;
    chk("arst_pre_valid", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_primed", 64'(primed), 64'd0);
    chk("arst_m_window", m_window, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_priming();
    test_streaming();
    test_backpressure();
    test_decimation();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_window.md
Name: fir_tap_window

Overview:
- Upstream feeder for the 4-tap 16-bit FIR filter stage.
- Accepts a serial stream of 16-bit samples over a valid/ready handshake and maintains a 4-deep sliding delay line.
- Presents the 4-sample window as one registered 64-bit word, with its own valid/ready handshake, directly on the filter's parallel data input.
- Supports priming after reset or flush, output decimation and backpressure.

Parameters:
- DW, 16, sample width; window width is 4*DW.
- STRIDE, 1, decimation factor: one window emitted per STRIDE accepted samples once primed; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of delay line, fill and stride state.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DW  input sample.
- m_valid  out  1  m_window holds an unconsumed window.
- m_ready  in  1  downstream consumes the window.
- m_window  out  4*DW  [DW-1:0] = newest x[n], [2DW-1:DW] = x[n-1], [3DW-1:2DW] = x[n-2], [4DW-1:3DW] = x[n-3] (oldest).
- primed  out  1  4 samples have been accepted since the last reset/flush.

Behaviour:
- Reset (rst_n low, async): delay line = 0, m_window = 0, m_valid = 0, primed = 0, fill_cnt = 0, stride_cnt = 0.
- Accept: occurs when s_valid && s_ready && !flush.
  - s_ready = !flush && (!m_valid || m_ready). This is combinational and does not depend on s_valid.
- On accept, the delay line shifts: x[n-3] <= x[n-2], x[n-2] <= x[n-1], x[n-1] <= x[n], x[n] <= s_data.
- State FILL (fill_cnt < 4):
  - Each accept increments fill_cnt.
  - The 4th accept sets primed = 1, moves to RUN, loads m_window with the shifted line, sets m_valid = 1 and clears stride_cnt to 0.
- State RUN:
  - Each accept increments stride_cnt.
  - When the post-increment value equals STRIDE, load m_window, set m_valid = 1 and reset stride_cnt to 0.
  - With STRIDE = 1, every accept emits a window.
- Latency: window is visible on m_window/m_valid the cycle after the accepting edge (1 cycle).
- Output hold: m_window is stable while m_valid && !m_ready.
- Clearing m_valid: m_valid clears on m_ready && m_valid unless a new window loads at the same edge. Consume plus a simultaneous emitting accept leaves m_valid = 1 with the new window (back-to-back throughput, 1 window/cycle at STRIDE = 1).
- Non-emitting accepts in RUN: these still shift the delay line but do not touch m_window or m_valid. They are permitted only when s_ready is high, so the shared stall rule applies regardless of STRIDE.
- Flush (synchronous, priority over everything):
  - Zeros the delay line and m_window.
  - m_valid = 0, primed = 0, fill_cnt = 0, stride_cnt = 0; state returns to FILL.
  - Any sample presented in the flush cycle is dropped (s_ready = 0).
- Async reset mid-operation aborts any pending window immediately. No partial state survives.
- Counters: fill_cnt is 3 bits, saturating at 4. stride_cnt is 4 bits and never exceeds STRIDE-1 at rest.
- No arithmetic on samples; data is passed bit-exact.

Test Plan:
- Priming, STRIDE = 1:
  - Stimulus: after reset, accept 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, m_ready = 1.
  - Required: m_valid first rises 1 cycle after the 4th accept, with m_window = 0x0001_0002_0003_0004; primed rises at the same cycle; no m_valid before that.
- Streaming, STRIDE = 1:
  - Stimulus: continue with 0x0005.
  - Required: next window = 0x0002_0003_0004_0005, m_valid stays 1 with no bubble.
- Backpressure:
  - Stimulus: hold m_ready = 0 while windows are pending.
  - Required: s_ready = 0, m_window frozen for 5 cycles. On m_ready = 1, the window is consumed, the pending s_data is accepted that same cycle, and the next window appears one cycle later.
- Decimation, STRIDE = 3:
  - Stimulus: feed samples 1..10.
  - Required: windows emitted after samples 4, 7 and 10 only: 0x0001_0002_0003_0004, 0x0004_0005_0006_0007, 0x0007_0008_0009_000A.
- Flush mid-stream:
  - Stimulus: after 2 accepted samples, assert flush for 1 cycle while s_valid = 1.
  - Required: the flush-cycle sample is dropped and primed = 0. Four further samples are needed before the next m_valid, and the window contains no pre-flush data.
- Async reset:
  - Stimulus: drop rst_n between clock edges while m_valid = 1.
  - Required: m_valid, primed and m_window go to 0 immediately, without waiting for a clock edge.
